// File: rtl/branch_pkg.sv
// Shared definitions for the SAP-2 branch sequencer: opcodes, flag bit positions, FSM encoding.
// The CALL/RET extension is enabled by defining BRANCH_CALL_EN.
package branch_pkg;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_JZ   = 3'b001;
    localparam logic [2:0] OP_JNZ  = 3'b010;
    localparam logic [2:0] OP_JM   = 3'b011;
    localparam logic [2:0] OP_JP   = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    // Bit positions inside the flags register output.
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_LOAD,
        ST_SKIP1,
        ST_SKIP2
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: latched opcode and flags -> taken / return / illegal.
// CALL and RET decode only when BRANCH_CALL_EN is defined; otherwise they are illegal.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [1:0] flags,
    output logic       taken,
    output logic       is_ret,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        is_ret  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = flags[FLAG_Z];
            OP_JNZ:  taken = ~flags[FLAG_Z];
            OP_JM:   taken = flags[FLAG_S];
            OP_JP:   taken = ~flags[FLAG_S];
`ifdef BRANCH_CALL_EN
            OP_CALL: taken = 1'b1;
            OP_RET:  is_ret = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// SAP-2 conditional branch sequencer: evaluates flags, fetches the 2-byte target, loads or skips PC.
// Define BRANCH_CALL_EN to add CALL/RET with a single-entry return register.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16   // must be 2*DATA_W: target is {hi, lo}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [1:0]        flags,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_val,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        flags_q, flags_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;

    logic taken, is_ret, illegal, bad_op, ret_valid;
    logic [ADDR_W-1:0] ret_addr;

`ifdef BRANCH_CALL_EN
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ret_valid_q, ret_valid_d;
    assign ret_addr  = ret_addr_q;
    assign ret_valid = ret_valid_q;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign ret_addr  = '0;
    assign ret_valid = 1'b0;
`endif

    branch_cond u_cond (
        .opcode  (op_q),
        .flags   (flags_q),
        .taken   (taken),
        .is_ret  (is_ret),
        .illegal (illegal)
    );

    // RET with nothing saved is treated like an illegal opcode.
    assign bad_op = illegal | (is_ret & ~ret_valid);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        flags_d = flags_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
`ifdef BRANCH_CALL_EN
        ret_addr_d  = ret_addr_q;
        ret_valid_d = ret_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    flags_d = flags;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (bad_op)      state_d = ST_IDLE;
                else if (is_ret) state_d = ST_LOAD;
                else if (taken)  state_d = ST_FETCH_LO;
                else             state_d = ST_SKIP1;
            end
            ST_FETCH_LO: begin
                if (mem_ready) begin
                    lo_d    = mem_data;
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_HI: begin
                if (mem_ready) begin
                    hi_d    = mem_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
`ifdef BRANCH_CALL_EN
                // pc already points past the operand bytes here.
                if (op_q == OP_CALL) begin
                    ret_addr_d  = pc;
                    ret_valid_d = 1'b1;
                end else if (op_q == OP_RET) begin
                    ret_valid_d = 1'b0;
                end
`endif
            end
            ST_SKIP1: state_d = ST_SKIP2;
            ST_SKIP2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            flags_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
`ifdef BRANCH_CALL_EN
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            flags_q <= flags_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
`ifdef BRANCH_CALL_EN
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
`endif
        end
    end

    // Outputs decode from the registered state; pc_inc also follows mem_ready so
    // the PC steps in the same cycle the byte is captured.
    always_comb begin
        mem_rd      = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
        pc_inc      = (mem_rd && mem_ready) || (state_q == ST_SKIP1) || (state_q == ST_SKIP2);
        pc_load     = (state_q == ST_LOAD);
        pc_load_val = '0;
        if (pc_load) pc_load_val = is_ret ? ret_addr : {hi_q, lo_q};
        busy        = (state_q != ST_IDLE);
        err         = (state_q == ST_EVAL) && bad_op;
        done        = pc_load || (state_q == ST_SKIP2) || err;
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer; CALL/RET cases follow BRANCH_CALL_EN.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  flags;
    logic [15:0] pc;
    logic        mem_rd;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0] mem [256];
    assign mem_data = mem[pc[7:0]];

    always #5 clk = ~clk;

    branch_sequencer #(.DATA_W(8), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .flags       (flags),
        .pc          (pc),
        .mem_rd      (mem_rd),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_tot = 0, n_pass = 0, n_fail = 0;
    int r_done, r_inc, r_ld, r_rd, r_err, r_ovl;
    logic [15:0] r_ldv;
    logic r_busy0, r_busy_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the bench-side PC register follows the pulses seen before the edge.
    task automatic tick();
        logic inc, ld;
        logic [15:0] v;
        inc = pc_inc; ld = pc_load; v = pc_load_val;
        @(posedge clk); #1;
        if (ld) pc = v;
        else if (inc) pc = pc + 16'd1;
    endtask

    // Issue one instruction at cycle 0; memory answers after wt wait cycles per byte.
    task automatic run(input logic [2:0] op, input logic [1:0] fl, input int wt, input int restart);
        int wcnt;
        wcnt = 0; r_done = -1; r_inc = 0; r_ld = 0; r_rd = 0; r_err = 0; r_ovl = 0;
        r_ldv = '0; r_busy0 = 1'bx; r_busy_after = 1'bx;
        opcode = op; flags = fl;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0) || (c == restart);
            if (c == 1) begin flags = ~fl; opcode = 3'b111; end
            mem_ready = 1'b0;
            #1;
            if (mem_rd) begin
                r_rd++;
                if (wcnt == wt) begin mem_ready = 1'b1; wcnt = 0; end
                else wcnt++;
            end
            #1;
            if (c == 0) r_busy0 = busy;
            if (pc_inc) r_inc++;
            if (pc_load) begin r_ld++; r_ldv = pc_load_val; end
            if (pc_inc && pc_load) r_ovl++;
            if (err) r_err++;
            if (done) begin
                r_done = c;
                tick();
                start = 1'b0; mem_ready = 1'b0;
                #2;
                r_busy_after = busy;
                break;
            end
            tick();
        end
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic chk_run(input string tag, input int e_done, input int e_inc, input int e_ld,
                           input logic [15:0] e_ldv, input int e_rd, input int e_err);
        chk({tag, ".busy0"}, r_busy0, 1'b0);
        chk({tag, ".done_cyc"}, r_done, e_done);
        chk({tag, ".pc_inc"}, r_inc, e_inc);
        chk({tag, ".pc_load"}, r_ld, e_ld);
        if (e_ld != 0) chk({tag, ".load_val"}, r_ldv, e_ldv);
        chk({tag, ".mem_rd_cyc"}, r_rd, e_rd);
        chk({tag, ".err"}, r_err, e_err);
        chk({tag, ".inc_and_load"}, r_ovl, 0);
        chk({tag, ".busy_after"}, r_busy_after, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h10] = 8'hcd; mem[8'h11] = 8'hab;
        rst_n = 1'b0; start = 1'b0; opcode = '0; flags = '0; mem_ready = 1'b0; pc = 16'h0100;
        #2;
        chk("reset.outs", {mem_rd, pc_inc, pc_load, busy, done, err}, 6'b0);
        chk("reset.load_val", pc_load_val, 16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // JZ taken, zero wait
        pc = 16'h0100;
        run(3'b001, 2'b10, 0, -1);
        chk_run("jz", 4, 2, 1, 16'h1234, 2, 0);

        // JNZ with Z=1 is not taken: two skip increments
        run(3'b010, 2'b10, 0, -1);
        chk_run("jnz", 3, 2, 0, 16'h0000, 0, 0);

        // JM with 3 wait cycles per byte and a stray start during FETCH_HI
        pc = 16'h0110;
        run(3'b011, 2'b01, 3, 7);
        chk_run("jm_wait", 10, 2, 1, 16'habcd, 8, 0);

        // Illegal opcode
        run(3'b111, 2'b00, 0, -1);
        chk_run("illegal", 1, 0, 0, 16'h0000, 0, 1);

        // Reset while waiting on the low operand byte
        pc = 16'h0100;
        opcode = 3'b000; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        #1;
        chk("rst_mid.fetching", mem_rd, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.outs", {mem_rd, pc_inc, pc_load, busy, done, err}, 6'b0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("rst_mid.idle", {busy, pc_load, mem_rd}, 3'b0);
        pc = 16'h0100;
        run(3'b100, 2'b00, 0, -1);
        chk_run("jp_after_rst", 4, 2, 1, 16'h1234, 2, 0);

`ifdef BRANCH_CALL_EN
        mem[8'h00] = 8'h00; mem[8'h01] = 8'h02;
        pc = 16'h0100;
        run(3'b101, 2'b00, 0, -1);
        chk_run("call", 4, 2, 1, 16'h0200, 2, 0);
        chk("call.pc", pc, 16'h0200);
        run(3'b110, 2'b00, 0, -1);
        chk_run("ret", 2, 0, 1, 16'h0102, 0, 0);
        run(3'b110, 2'b00, 0, -1);
        chk_run("ret2", 1, 0, 0, 16'h0000, 0, 1);
`else
        run(3'b101, 2'b00, 0, -1);
        chk_run("call_off", 1, 0, 0, 16'h0000, 0, 1);
        run(3'b110, 2'b00, 0, -1);
        chk_run("ret_off", 1, 0, 0, 16'h0000, 0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
